// File: rtl/ysyx_22041071_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041071_ifu_pkg
// Brief    : Shared AXI codes, FSM state encoding and word-select helper for the IFU
// Revision : 1.0
// ============================================================================
package ysyx_22041071_ifu_pkg;

  localparam logic [1:0] SIZE_D     = 2'b11;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         FETCH_ID_D = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_OUT  = 2'd3
  } ifu_state_e;

  // Picks the 32-bit instruction slot of a 64-bit beat using address bit 2.
  function automatic logic [31:0] sel_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041071_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041071_ifu
// Brief    : Single-outstanding instruction fetch over AXI4 read, 32-bit select
// Revision : 1.0
// ============================================================================
module ysyx_22041071_ifu
  import ysyx_22041071_ifu_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 8,
  parameter int ID_W     = 4,
  parameter int FETCH_ID = FETCH_ID_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ar_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LEN_W-1:0]  cpu_len,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] PC,
  output logic              ready1,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [LEN_W-1:0]  ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  output logic [ID_W-1:0]   ar_id,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  input  logic              r_last,
  input  logic [ID_W-1:0]   r_id,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [1:0]        inst_err
);

  ifu_state_e        r_state;
  ifu_state_e        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_pc;
  logic [LEN_W-1:0]  r_cnt;
  logic [31:0]       r_inst;
  logic [1:0]        r_err;
  logic              w_accept;
  logic              w_misalign;
  logic              w_beat;
  logic              w_done;

  assign w_accept   = (r_state == ST_IDLE) && cpu_ar_valid;
  assign w_misalign = (cpu_addr[1:0] != 2'b00);
  // Beats tagged with a foreign ID are handshaken but otherwise ignored.
  assign w_beat     = (r_state == ST_R) && r_valid && (r_id == ID_W'(FETCH_ID));
  assign w_done     = w_beat && (r_last || (r_cnt == r_len));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (cpu_ar_valid) w_next = w_misalign ? ST_OUT : ST_AR;
      ST_AR:   if (ar_ready)     w_next = ST_R;
      ST_R:    if (w_done)       w_next = ST_OUT;
      ST_OUT:  if (inst_ready)   w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_pc   <= '0;
      r_cnt  <= '0;
      r_inst <= '0;
      r_err  <= '0;
    end else if (w_accept) begin
      r_addr <= cpu_addr;
      r_len  <= cpu_len;
      r_size <= cpu_size;
      r_pc   <= PC;
      r_cnt  <= '0;
      r_inst <= '0;
      r_err  <= w_misalign ? 2'b10 : 2'b00;
    end else if (w_beat) begin
      if (r_cnt == '0) r_inst <= sel_word(r_data[63:0], r_addr[2]);
      if (r_resp != RESP_OKAY) r_err[0] <= 1'b1;
      r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  assign ready1     = (r_state == ST_IDLE);
  assign ar_valid   = (r_state == ST_AR);
  assign r_ready    = (r_state == ST_R);
  assign inst_valid = (r_state == ST_OUT);

  assign ar_addr  = {r_addr[ADDR_W-1:3], 3'b000};
  assign ar_len   = r_len;
  assign ar_size  = {1'b0, r_size};
  assign ar_burst = BURST_INCR;
  assign ar_id    = ID_W'(FETCH_ID);

  assign inst     = r_inst;
  assign inst_pc  = r_pc;
  assign inst_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041071_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041071_ifu
// Brief    : Scoreboard bench for the IFU with a behavioural fetch model
// Revision : 1.0
// ============================================================================
module tb_ysyx_22041071_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ar_valid;
  logic [63:0] cpu_addr;
  logic [7:0]  cpu_len;
  logic [1:0]  cpu_size;
  logic [63:0] PC;
  logic        ready1;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_id;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [3:0]  r_id;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  inst_err;

  always #5 clk = ~clk;

  ysyx_22041071_ifu dut (
    .clk(clk), .reset(reset),
    .cpu_ar_valid(cpu_ar_valid), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
    .cpu_size(cpu_size), .PC(PC), .ready1(ready1),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .r_id(r_id),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  int   ar_hs = 0;
  int   exp_ar_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (reset && ar_valid && ar_ready) ar_hs <= ar_hs + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Monitor: drives decode backpressure and checks every presented instruction.
  initial begin
    inst_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) inst_ready = 1'b0;
      else              inst_ready = ($urandom % 4) != 0;
      if (reset && inst_valid) begin
        if (hold_cnt > 0) hold_cnt--;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected actual=%h expected=none", inst);
        end else begin
          chk("inst", {32'h0, inst}, {32'h0, sb[0].inst});
          chk("inst_pc", inst_pc, sb[0].pc);
          chk("inst_err", {62'h0, inst_err}, {62'h0, sb[0].err});
          if (inst_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drain();
    for (int t = 0; t < 500; t++) begin
      if (sb.size() == 0 && ready1) return;
      @(negedge clk);
    end
    abort_run("drain");
  endtask

  // One fetch: model predicts the instruction, then the task plays PC stage and AXI slave.
  task automatic fetch(input logic [63:0] addr, input logic [63:0] pc, input logic [63:0] d0,
                       input int len, input int nbeats, input bit last_flag, input int ar_delay,
                       input bit gaps, input bit rand_resp, input logic [1:0] resp0,
                       input bit chk_lat);
    logic [63:0] d[$];
    logic [1:0]  rs[$];
    exp_t        e;
    bit          mis;
    bit          anyerr;
    int          acc;
    int          t;
    mis = (addr[1:0] != 2'b00);
    anyerr = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      d.push_back(i == 0 ? d0 : {$urandom, $urandom});
      if (rand_resp) rs.push_back(($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      else           rs.push_back(i == 0 ? resp0 : 2'b00);
      if (rs[i] != 2'b00) anyerr = 1'b1;
    end
    e.pc = pc;
    if (mis) begin
      e.inst = 32'h0;
      e.err  = 2'b10;
    end else begin
      e.inst = addr[2] ? d[0][63:32] : d[0][31:0];
      e.err  = {1'b0, anyerr};
    end
    sb.push_back(e);

    cpu_ar_valid = 1'b1;
    cpu_addr = addr;
    cpu_len  = 8'(len);
    cpu_size = 2'b11;
    PC       = pc;
    t = 0;
    while (!ready1) begin
      @(negedge clk);
      t++;
      if (t > 500) abort_run("accept");
    end
    acc = cyc;
    @(negedge clk);
    cpu_ar_valid = 1'b0;
    cpu_addr = {$urandom, $urandom};
    cpu_len  = 8'($urandom);
    PC       = {$urandom, $urandom};
    if (mis) begin
      chk("mis_no_ar", {63'h0, ar_valid}, 64'h0);
      if (chk_lat) chk("mis_latency", {63'h0, inst_valid}, 64'h1);
      return;
    end
    exp_ar_hs++;
    for (int k = 0; k < ar_delay; k++) begin
      ar_ready = 1'b0;
      chk("ar_valid_wait", {63'h0, ar_valid}, 64'h1);
      chk("ar_addr_wait", ar_addr, {addr[63:3], 3'b000});
      @(negedge clk);
    end
    ar_ready = 1'b1;
    chk("ar_valid", {63'h0, ar_valid}, 64'h1);
    chk("ar_addr", ar_addr, {addr[63:3], 3'b000});
    chk("ar_len", {56'h0, ar_len}, 64'(len));
    chk("ar_size", {61'h0, ar_size}, 64'h3);
    chk("ar_burst_id", {58'h0, ar_burst, ar_id}, {58'h0, 2'b01, 4'h0});
    @(negedge clk);
    ar_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        r_valid = 1'b0;
        @(negedge clk);
      end
      if (gaps && ($urandom % 4 == 0)) begin
        r_valid = 1'b1;
        r_id    = 4'h5;
        r_data  = {$urandom, $urandom};
        r_resp  = 2'b10;
        r_last  = 1'b1;
        chk("r_ready_foreign", {63'h0, r_ready}, 64'h1);
        @(negedge clk);
      end
      r_valid = 1'b1;
      r_id    = 4'h0;
      r_data  = d[i];
      r_resp  = rs[i];
      r_last  = (i == nbeats - 1) && (last_flag || nbeats < len + 1);
      chk("r_ready_beat", {63'h0, r_ready}, 64'h1);
      @(negedge clk);
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    chk("r_ready_done", {63'h0, r_ready}, 64'h0);
    if (chk_lat) begin
      chk("latency", 64'(cyc - acc), 64'd3);
      chk("latency_valid", {63'h0, inst_valid}, 64'h1);
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_ar_valid = 1'b0; cpu_addr = '0; cpu_len = '0; cpu_size = 2'b11; PC = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0; r_id = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready1", {63'h0, ready1}, 64'h1);
    chk("rst_handshakes", {61'h0, ar_valid, r_ready, inst_valid}, 64'h0);
    chk("rst_outputs", {30'h0, inst, inst_err}, 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_ar", ar_addr | {53'h0, ar_len, ar_size}, 64'h0);
    chk("rst_const", {58'h0, ar_burst, ar_id}, {58'h0, 2'b01, 4'h0});
    reset = 1'b1;
    @(negedge clk);

    fetch(64'h8000_0004, 64'h8000_0004, 64'h1111_2222_3333_4444, 0, 1, 1, 0, 0, 0, 2'b00, 1);
    drain();
    fetch(64'h8000_0000, 64'h8000_0000, 64'h1111_2222_3333_4444, 0, 1, 1, 0, 0, 0, 2'b00, 1);
    drain();
    hold_cnt = 4;
    fetch(64'h8000_0008, 64'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 1, 5, 0, 0, 2'b00, 0);
    drain();
    fetch(64'h8000_000C, 64'h8000_000C, 64'h1234_5678_9ABC_DEF0, 0, 1, 1, 0, 0, 0, 2'b10, 0);
    drain();
    fetch(64'h8000_0010, 64'h8000_0010, 64'hCAFE_F00D_DEAD_BEEF, 3, 4, 1, 0, 0, 0, 2'b00, 0);
    drain();
    fetch(64'h8000_0002, 64'h8000_0002, 64'h0, 0, 1, 1, 0, 0, 0, 2'b00, 1);
    drain();

    // Reset pulled while waiting for read data.
    cpu_ar_valid = 1'b1; cpu_addr = 64'h8000_0010; cpu_len = 8'd2; PC = 64'h0000_1234;
    @(negedge clk);
    cpu_ar_valid = 1'b0;
    ar_ready = 1'b1;
    exp_ar_hs++;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("pre_rst_r_ready", {63'h0, r_ready}, 64'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready1", {63'h0, ready1}, 64'h1);
    chk("mid_rst_handshakes", {61'h0, ar_valid, r_ready, inst_valid}, 64'h0);
    chk("mid_rst_inst_pc", inst_pc, 64'h0);
    chk("mid_rst_ar", ar_addr | {53'h0, ar_len, ar_size}, 64'h0);
    chk("mid_rst_err", {62'h0, inst_err}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fetch(64'h8000_0000, 64'h8000_0100, 64'h0BAD_C0DE_600D_F00D, 0, 1, 1, 0, 0, 0, 2'b00, 1);

    for (int n = 0; n < 300; n++) begin
      logic [63:0] a;
      int          len;
      int          nb;
      a = 64'h8000_0000 + {32'h0, 16'h0, 16'($urandom)};
      a[1:0] = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      len = $urandom_range(0, 3);
      nb  = ($urandom % 3 == 0) ? $urandom_range(1, len + 1) : len + 1;
      fetch(a, {$urandom, $urandom}, {$urandom, $urandom}, len, nb, 1'($urandom % 2),
            $urandom_range(0, 3), 1, 1, 2'b00, 0);
    end
    drain();
    chk("ar_handshake_count", 64'(ar_hs), 64'(exp_ar_hs));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041071_ifu.md
# ysyx_22041071_ifu

Instruction-fetch unit sitting directly downstream of the PC stage. It accepts one fetch request at a time from the PC stage (valid/ready1 handshake plus address/len/size), drives the AXI4 read address and read data channels toward the memory interconnect, and selects the 32-bit instruction out of the returned 64-bit beat. It presents instruction, fetch PC and error flags to the decode stage over a valid/ready handshake.

## Interface
- ADDR_W, 64, address/PC width
- DATA_W, 64, AXI read data width
- LEN_W, 8, AXI burst length width
- ID_W, 4, AXI ID width
- FETCH_ID, 0, AXI ID used for every fetch
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_ar_valid  in  1  fetch request valid from PC stage
- cpu_addr  in  ADDR_W  fetch byte address
- cpu_len  in  LEN_W  burst length minus one
- cpu_size  in  2  beat size code (2'b11 = 8 bytes)
- PC  in  ADDR_W  PC of the requested instruction
- ready1  out  1  request accepted this cycle (to PC stage)
- ar_valid / ar_ready  out / in  1  AXI AR handshake
- ar_addr  out  ADDR_W  cpu_addr with bits [2:0] cleared
- ar_len  out  LEN_W  captured cpu_len
- ar_size  out  3  {1'b0, captured cpu_size}
- ar_burst  out  2  constant 2'b01 (INCR)
- ar_id  out  ID_W  constant FETCH_ID
- r_valid / r_ready  in / out  1  AXI R handshake
- r_data  in  DATA_W  read data
- r_resp  in  2  read response
- r_last  in  1  last beat
- r_id  in  ID_W  response ID
- inst_valid / inst_ready  out / in  1  decode handshake
- inst  out  32  fetched instruction
- inst_pc  out  ADDR_W  PC of inst
- inst_err  out  2  bit0 bus error, bit1 misaligned fetch

## Operation
- FSM states: IDLE, AR, R, OUT. Reset state IDLE.
- IDLE: ready1=1. On cpu_ar_valid: capture addr, len, size, PC; clear err and beat counter. If cpu_addr[1:0]!=0 -> OUT with inst=0, inst_err=2'b10, no AXI traffic; else -> AR.
- AR: ar_valid=1; ar_* stable until ar_ready; on ar_ready -> R.
- R: r_ready=1. Beats with r_id!=FETCH_ID are consumed and ignored. Matching beat: beat 0 loads inst = addr[2] ? r_data[63:32] : r_data[31:0]; any r_resp!=2'b00 sets inst_err[0] (sticky for the transaction); counter increments. Leave R when r_last=1 or counter reaches captured len, whichever first -> OUT. Beats after beat 0 are discarded.
- OUT: inst_valid=1; inst, inst_pc, inst_err stable until inst_ready; on inst_ready -> IDLE.
- ready1, ar_valid, r_ready, inst_valid are pure decodes of state.

## Timing
- Reset values: ready1=1, ar_valid=0, r_ready=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0, ar_addr=0, ar_len=0, ar_size=0; ar_burst/ar_id constant.
- Reset asserted mid-transaction: asynchronously to IDLE, outstanding AXI transaction abandoned (interconnect shares reset).
- Minimum latency, zero-wait memory: request accepted cycle 0, ar_valid cycle 1 (ar_ready same cycle), r_ready cycle 2 (r_valid same cycle), inst_valid cycle 3; next request accepted cycle 4 earliest if inst_ready in cycle 3.
- Misaligned path: inst_valid at cycle 1.
- One outstanding fetch; no request accepted outside IDLE.
- Backpressure: inst_ready low holds OUT indefinitely with stable outputs.

## Structure
- Shared define file: AXI size code SIZE_D, BURST_INCR=2'b01, RESP_OKAY=2'b00, FSM state encodings, default FETCH_ID.
- Single module; no sub-module required.

## Test plan
- Aligned fetch, cpu_addr=0x8000_0004, r_data=0x1111_2222_3333_4444, OKAY -> ar_addr=0x8000_0000, inst=0x1111_2222, inst_pc=PC, inst_err=0, inst_valid at cycle 3.
- cpu_addr=0x8000_0000 with same data -> inst=0x3333_4444.
- ar_ready delayed 5 cycles, inst_ready low 4 cycles -> ar_* stable throughout, single AR handshake, outputs stable, one instruction delivered.
- r_resp=2'b10 (SLVERR) -> inst_err=2'b01, inst_valid asserted; cpu_len=3 burst with OKAY on all 4 beats -> instruction from beat 0 only, exit on r_last.
- cpu_addr=0x8000_0002 -> no ar_valid ever, inst_err=2'b10, inst=0, inst_valid at cycle 1.
- reset driven low while in R -> all outputs at reset values immediately; new request at 0x8000_0000 after release completes normally.
